// File: rtl/des_key_schedule_seq.sv
// DES / 3DES-EDE key schedule: emits the 16*NKEYS round subkeys of one job in
// cipher consumption order over a valid/ready stream, one subkey per handshake.
module des_key_schedule_seq #(
    parameter int NKEYS     = 1,
    parameter bit PARITY_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  encrypt,
    input  logic [64*NKEYS-1:0]   key_in,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic                  abort,
    output logic [47:0]           subkey_out,
    output logic [3:0]            subkey_idx,
    output logic [1:0]            subkey_stage,
    output logic                  subkey_last,
    output logic                  subkey_valid,
    input  logic                  subkey_ready,
    output logic [NKEYS-1:0]      parity_err
);

    typedef enum logic {IDLE, GEN} state_t;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // FIPS bit n (1 = MSB) lives at vector position width-n.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_T[i])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
        return r;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt,
                                          input logic left);
        logic [27:0] r;
        case (amt)
            2'd1:    r = left ? {x[26:0], x[27]}    : {x[0], x[27:1]};
            2'd2:    r = left ? {x[25:0], x[27:26]} : {x[1:0], x[27:2]};
            default: r = x;
        endcase
        return r;
    endfunction

    // Shift before the n-th emission of a stage (n >= 1); symmetric for both directions.
    function automatic logic [1:0] rot_amt(input logic [3:0] n);
        return (n == 4'd1 || n == 4'd8 || n == 4'd15) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [63:0] key_pick(input logic [64*NKEYS-1:0] keys,
                                             input logic [1:0] k);
        logic [64*NKEYS-1:0] sh;
        sh = keys >> (64 * (NKEYS - 1 - int'(k)));
        return sh[63:0];
    endfunction

    function automatic logic parity_bad(input logic [63:0] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) bad = bad | ~(^k[8*b +: 8]);
        return bad;
    endfunction

    state_t              state_q;
    logic                rdy_q, vld_q, last_q, enc_q;
    logic [47:0]         sk_q;
    logic [3:0]          idx_q, cnt_q;
    logic [1:0]          stage_q;
    logic [NKEYS-1:0]    par_q;
    logic [64*NKEYS-1:0] key_q;
    logic [27:0]         c_q, d_q;

    logic                accept, advance, load, ld_enc, dir, last_d;
    logic [1:0]          stage_d, kidx;
    logic [3:0]          cnt_d, idx_d;
    logic [63:0]         ld_key;
    logic [55:0]         pc1_v;
    logic [27:0]         c_d, d_d;
    logic [47:0]         sk_d;
    logic [NKEYS-1:0]    par_d;

    for (genvar g = 0; g < NKEYS; g++) begin : g_par
        assign par_d[g] = PARITY_EN && parity_bad(key_in[64*g +: 64]);
    end

    always_comb begin
        accept  = key_valid && rdy_q && !abort;
        advance = (state_q == GEN) && vld_q && subkey_ready && !abort && !last_q;
        // A new stage loads PC-1 of its key in the same cycle the previous stage ends.
        load    = accept || (advance && cnt_q == 4'd15);
        ld_enc  = accept ? encrypt : enc_q;
        stage_d = accept ? 2'd0 : (load ? stage_q + 2'd1 : stage_q);
        dir     = ld_enc ^ stage_d[0];
        kidx    = ld_enc ? stage_d : 2'(NKEYS - 1) - stage_d;
        ld_key  = key_pick(accept ? key_in : key_q, kidx);
        pc1_v   = pc1(ld_key);
        cnt_d   = load ? 4'd0 : cnt_q + 4'd1;
        if (load) begin
            c_d = dir ? rot28(pc1_v[55:28], 2'd1, 1'b1) : pc1_v[55:28];
            d_d = dir ? rot28(pc1_v[27:0], 2'd1, 1'b1) : pc1_v[27:0];
        end else begin
            c_d = rot28(c_q, rot_amt(cnt_d), dir);
            d_d = rot28(d_q, rot_amt(cnt_d), dir);
        end
        idx_d  = dir ? cnt_d : 4'd15 - cnt_d;
        last_d = (stage_d == 2'(NKEYS - 1)) && (cnt_d == 4'd15);
        sk_d   = pc2({c_d, d_d});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            sk_q    <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            par_q   <= '0;
        end else if (state_q == IDLE) begin
            if (accept) begin
                state_q <= GEN;
                rdy_q   <= 1'b0;
                vld_q   <= 1'b1;
                par_q   <= par_d;
                sk_q    <= sk_d;
                idx_q   <= idx_d;
                stage_q <= stage_d;
                last_q  <= last_d;
                cnt_q   <= cnt_d;
            end
        end else begin
            if (abort || (vld_q && subkey_ready && last_q)) begin
                state_q <= IDLE;
                rdy_q   <= 1'b1;
                vld_q   <= 1'b0;
            end else if (advance) begin
                sk_q    <= sk_d;
                idx_q   <= idx_d;
                stage_q <= stage_d;
                last_q  <= last_d;
                cnt_q   <= cnt_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            enc_q <= encrypt;
            key_q <= key_in;
        end
        if (accept || advance) begin
            c_q <= c_d;
            d_q <= d_d;
        end
    end

    assign key_ready    = rdy_q;
    assign subkey_valid = vld_q;
    assign subkey_out   = sk_q;
    assign subkey_idx   = idx_q;
    assign subkey_stage = stage_q;
    assign subkey_last  = last_q;
    assign parity_err   = par_q;

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Scoreboard bench for des_key_schedule_seq: single-DES and 3DES instances,
// expected subkeys queued at job issue and popped by per-instance monitors.
module tb_des_key_schedule_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         enc1, kv1, kr1, abo1, v1, r1, l1;
    logic [63:0]  key1;
    logic [47:0]  sk1;
    logic [3:0]   i1;
    logic [1:0]   s1;
    logic [0:0]   p1;

    logic         enc3, kv3, kr3, abo3, v3, r3, l3;
    logic [191:0] key3;
    logic [47:0]  sk3;
    logic [3:0]   i3;
    logic [1:0]   s3;
    logic [2:0]   p3;

    des_key_schedule_seq #(.NKEYS(1), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .encrypt(enc1), .key_in(key1), .key_valid(kv1),
        .key_ready(kr1), .abort(abo1), .subkey_out(sk1), .subkey_idx(i1),
        .subkey_stage(s1), .subkey_last(l1), .subkey_valid(v1),
        .subkey_ready(r1), .parity_err(p1));

    des_key_schedule_seq #(.NKEYS(3), .PARITY_EN(1)) dut3 (
        .clk(clk), .rst(rst), .encrypt(enc3), .key_in(key3), .key_valid(kv3),
        .key_ready(kr3), .abort(abo3), .subkey_out(sk3), .subkey_idx(i3),
        .subkey_stage(s3), .subkey_last(l3), .subkey_valid(v3),
        .subkey_ready(r3), .parity_err(p3));

    typedef logic [54:0] rec_t;   // {subkey, idx, stage, last}
    rec_t q1[$];
    rec_t q3[$];

    int ntot = 0;
    int npass = 0;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] KS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // kt: 0 = test key, 1 = all-zero effective key, 2 = all-ones effective key
    function automatic logic [47:0] exp_sk(input int kt, input int i);
        case (kt)
            0:       return KS[i];
            1:       return 48'h0;
            default: return 48'hFFFFFFFFFFFF;
        endcase
    endfunction

    task automatic push_stage(input int dut, input int kt, input bit asc, input int stage,
                              input bit fin);
        for (int n = 0; n < 16; n++) begin
            int i;
            rec_t r;
            i = asc ? n : 15 - n;
            r = {exp_sk(kt, i), 4'(i), 2'(stage), 1'(fin && n == 15)};
            if (dut == 1) q1.push_back(r);
            else q3.push_back(r);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && v1) begin
            if (q1.size() == 0) begin
                ntot++;
                $display("FAIL d1_extra: got subkey %h idx %0d expected none", sk1, i1);
            end else begin
                check("d1_subkey", 64'({sk1, i1, s1, l1}), 64'(q1[0]));
                if (r1) q1.delete(0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && v3) begin
            if (q3.size() == 0) begin
                ntot++;
                $display("FAIL d3_extra: got subkey %h idx %0d stage %0d expected none",
                         sk3, i3, s3);
            end else begin
                check("d3_subkey", 64'({sk3, i3, s3, l3}), 64'(q3[0]));
                if (r3) q3.delete(0);
            end
        end
    end

    task automatic start1(input logic [63:0] k, input logic e, input logic [0:0] par);
        key1 = k; enc1 = e; kv1 = 1'b1;
        @(posedge clk); #1;
        kv1 = 1'b0;
        check("d1_parity", 64'(p1), 64'(par));
    endtask

    task automatic start3(input logic [191:0] k, input logic e, input logic [2:0] par);
        key3 = k; enc3 = e; kv3 = 1'b1;
        @(posedge clk); #1;
        kv3 = 1'b0;
        check("d3_parity", 64'(p3), 64'(par));
    endtask

    task automatic wait1(input int exp_cyc, input bit rnd, input string nm);
        int n = 0;
        while (q1.size() != 0 && n < 1000) begin
            if (rnd) r1 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        r1 = 1'b1;
        if (exp_cyc >= 0) check({nm, "_cycles"}, 64'(n), 64'(exp_cyc));
        else check({nm, "_done"}, 64'(n < 1000), 64'(1));
        @(negedge clk);
        check({nm, "_idle"}, 64'({kr1, v1}), 64'(2'b10));
        @(posedge clk); #1;
    endtask

    task automatic wait3(input int exp_cyc, input string nm);
        int n = 0;
        while (q3.size() != 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_cycles"}, 64'(n), 64'(exp_cyc));
        @(negedge clk);
        check({nm, "_idle"}, 64'({kr3, v3}), 64'(2'b10));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        kv1 = 1'b0; enc1 = 1'b0; key1 = '0; abo1 = 1'b0; r1 = 1'b1;
        kv3 = 1'b0; enc3 = 1'b0; key3 = '0; abo3 = 1'b0; r3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("d1_reset_ctl",  64'({kr1, v1, l1, p1}), 64'(4'b1000));
        check("d1_reset_data", 64'({sk1, i1, s1}), 64'(0));
        check("d3_reset_ctl",  64'({kr3, v3, l3, p3}), 64'(6'b100000));
        check("d3_reset_data", 64'({sk3, i3, s3}), 64'(0));
        rst = 1'b0;

        // abort beats key_valid in IDLE
        key1 = KEY; enc1 = 1'b1; kv1 = 1'b1; abo1 = 1'b1;
        @(posedge clk); #1;
        kv1 = 1'b0; abo1 = 1'b0;
        check("d1_abort_idle", 64'({kr1, v1}), 64'(2'b10));

        // single DES encrypt
        push_stage(1, 0, 1, 0, 1);
        start1(KEY, 1'b1, 1'b0);
        wait1(16, 1'b0, "d1_enc");

        // single DES decrypt, with a key_valid pulse while busy
        push_stage(1, 0, 0, 0, 1);
        start1(KEY, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        key1 = 64'h0; enc1 = 1'b1; kv1 = 1'b1;
        @(posedge clk); #1;
        kv1 = 1'b0;
        check("d1_busy_ready", 64'(kr1), 64'(0));
        wait1(12, 1'b0, "d1_dec");

        // random back-pressure
        push_stage(1, 0, 1, 0, 1);
        start1(KEY, 1'b1, 1'b0);
        wait1(-1, 1'b1, "d1_stall");

        // abort after the fifth subkey
        push_stage(1, 0, 1, 0, 1);
        start1(KEY, 1'b1, 1'b0);
        n = 0;
        while (q1.size() != 11 && n < 100) begin @(posedge clk); #1; n++; end
        check("d1_abort_reach", 64'(q1.size()), 64'(11));
        abo1 = 1'b1; r1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("d1_abort", 64'({kr1, v1}), 64'(2'b10));
        @(posedge clk); #1;
        abo1 = 1'b0; r1 = 1'b1;
        q1.delete();

        // zero key: parity error, all-zero subkeys
        push_stage(1, 1, 1, 0, 1);
        start1(64'h0, 1'b1, 1'b1);
        wait1(16, 1'b0, "d1_zero");
        check("d1_parity_hold", 64'(p1), 64'(1));

        // 3DES-EDE encrypt, identical keys
        push_stage(3, 0, 1, 0, 0);
        push_stage(3, 0, 0, 1, 0);
        push_stage(3, 0, 1, 2, 1);
        start3({KEY, KEY, KEY}, 1'b1, 3'b000);
        wait3(48, "d3_ede_enc");

        // zero key in slot 2
        push_stage(3, 0, 1, 0, 0);
        push_stage(3, 1, 0, 1, 0);
        push_stage(3, 0, 1, 2, 1);
        start3({KEY, 64'h0, KEY}, 1'b1, 3'b010);
        wait3(48, "d3_par");
        check("d3_parity_hold", 64'(p3), 64'(3'b010));

        // 3DES decrypt, three distinct keys: key3 first
        push_stage(3, 2, 0, 0, 0);
        push_stage(3, 1, 1, 1, 0);
        push_stage(3, 0, 0, 2, 1);
        start3({KEY, 64'h0101010101010101, 64'hFEFEFEFEFEFEFEFE}, 1'b0, 3'b000);
        wait3(48, "d3_dec");

        // reset in the middle of a job
        push_stage(3, 0, 1, 0, 0);
        push_stage(3, 0, 0, 1, 0);
        push_stage(3, 0, 1, 2, 1);
        start3({KEY, KEY, KEY}, 1'b1, 3'b000);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        q3.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("d3_rst_ctl",  64'({kr3, v3, l3, p3}), 64'(6'b100000));
        check("d3_rst_data", 64'({sk3, i3, s3}), 64'(0));
        check("d1_rst_parity", 64'(p1), 64'(0));
        repeat (4) begin @(posedge clk); #1; end
        check("d3_rst_quiet", 64'({kr3, v3}), 64'(2'b10));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
